// File: rtl/div_unit_pkg.sv
// Shared constants and state encoding for the multi-cycle DIV/DIVU unit.
// Also carries the DIV/DIVU control codes that decode uses to drive start/signed_div.
package div_unit_pkg;

    localparam logic [5:0] DIV_CONTROL  = 6'h1A;
    localparam logic [5:0] DIVU_CONTROL = 6'h1B;

    localparam int unsigned DIV_ITERS    = 32;
    localparam logic [5:0]  DIV_CNT_LAST = 6'(DIV_ITERS - 1);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic is_last_iter(input logic [5:0] cnt);
        return (cnt == DIV_CNT_LAST);
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Execute-stage request/response bundle between the pipeline and div_unit.
interface div_unit_if #(parameter int DATA_W = 32);

    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              signed_div;
    logic              start;
    logic              annul;
    logic              stall_o;
    logic              valid_o;
    logic [DATA_W-1:0] hi_div_out;
    logic [DATA_W-1:0] lo_div_out;

    modport master (
        output a, b, signed_div, start, annul,
        input  stall_o, valid_o, hi_div_out, lo_div_out
    );

    modport slave (
        input  a, b, signed_div, start, annul,
        output stall_o, valid_o, hi_div_out, lo_div_out
    );

endinterface

// File: rtl/div_abs.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fixes.
module div_abs #(parameter int DATA_W = 32) (
    input  logic [DATA_W-1:0] value,
    input  logic              en,
    output logic [DATA_W-1:0] result
);

    assign result = en ? (~value + {{(DATA_W-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for MIPS DIV/DIVU: quotient to LO, remainder to HI.
// Optional DIV_EARLY_OUT_EN finishes in one cycle when |a| < |b|.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic       clk,
    input  logic       resetn,
    div_unit_if.slave  bus
);

    div_state_e        state_r, state_s;
    logic [DATA_W-1:0] rem_r, rem_s;
    logic [DATA_W-1:0] quo_r, quo_s;
    logic [DATA_W-1:0] dvs_r, dvs_s;
    logic [5:0]        cnt_r, cnt_s;
    logic              q_neg_r, q_neg_s;
    logic              r_neg_r, r_neg_s;

    logic [DATA_W-1:0] mag_a_s, mag_b_s, quo_fix_s, rem_fix_s;
    logic [DATA_W:0]   rem_sh_s, trial_s;
    logic              accept_s, b_zero_s, early_s;
    logic              stall_s, valid_s;

    div_abs #(.DATA_W(DATA_W)) u_abs_a (
        .value (bus.a),
        .en    (bus.signed_div & bus.a[DATA_W-1]),
        .result(mag_a_s)
    );

    div_abs #(.DATA_W(DATA_W)) u_abs_b (
        .value (bus.b),
        .en    (bus.signed_div & bus.b[DATA_W-1]),
        .result(mag_b_s)
    );

    div_abs #(.DATA_W(DATA_W)) u_fix_quo (
        .value (quo_r),
        .en    (q_neg_r),
        .result(quo_fix_s)
    );

    div_abs #(.DATA_W(DATA_W)) u_fix_rem (
        .value (rem_r),
        .en    (r_neg_r),
        .result(rem_fix_s)
    );

    assign accept_s = resetn & (state_r == DIV_IDLE) & bus.start & ~bus.annul;
    assign b_zero_s = (bus.b == {DATA_W{1'b0}});
    assign rem_sh_s = {rem_r, quo_r[DATA_W-1]};
    assign trial_s  = rem_sh_s - {1'b0, dvs_r};

`ifdef DIV_EARLY_OUT_EN
    assign early_s = ~b_zero_s & (mag_a_s < mag_b_s);
`else
    assign early_s = 1'b0;
`endif

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_s = state_r;
        rem_s   = rem_r;
        quo_s   = quo_r;
        dvs_s   = dvs_r;
        cnt_s   = cnt_r;
        q_neg_s = q_neg_r;
        r_neg_s = r_neg_r;
        stall_s = 1'b0;
        valid_s = 1'b0;
        case (state_r)
            DIV_IDLE: begin
                if (accept_s) begin
                    stall_s = 1'b1;
                    dvs_s   = mag_b_s;
                    cnt_s   = 6'd0;
                    r_neg_s = bus.signed_div & bus.a[DATA_W-1];
                    q_neg_s = bus.signed_div & (bus.a[DATA_W-1] ^ bus.b[DATA_W-1]);
                    rem_s   = mag_a_s;
                    if (b_zero_s) begin
                        // Remainder keeps its sign fix so HI reproduces a; quotient stays all-ones.
                        quo_s   = {DATA_W{1'b1}};
                        q_neg_s = 1'b0;
                        state_s = DIV_DONE;
                    end else if (early_s) begin
                        quo_s   = {DATA_W{1'b0}};
                        state_s = DIV_DONE;
                    end else begin
                        quo_s   = mag_a_s;
                        rem_s   = {DATA_W{1'b0}};
                        state_s = DIV_BUSY;
                    end
                end else begin
                    state_s = DIV_IDLE;
                end
            end
            DIV_BUSY: begin
                stall_s = 1'b1;
                if (bus.annul) begin
                    state_s = DIV_IDLE;
                end else begin
                    quo_s = {quo_r[DATA_W-2:0], ~trial_s[DATA_W]};
                    rem_s = trial_s[DATA_W] ? rem_sh_s[DATA_W-1:0] : trial_s[DATA_W-1:0];
                    cnt_s = cnt_r + 6'd1;
                    if (is_last_iter(cnt_r)) begin
                        state_s = DIV_DONE;
                    end else begin
                        state_s = DIV_BUSY;
                    end
                end
            end
            DIV_DONE: begin
                valid_s = ~bus.annul;
                state_s = DIV_IDLE;
            end
            default: begin
                state_s = DIV_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= DIV_IDLE;
            rem_r   <= {DATA_W{1'b0}};
            quo_r   <= {DATA_W{1'b0}};
            dvs_r   <= {DATA_W{1'b0}};
            cnt_r   <= 6'd0;
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            state_r <= state_s;
            rem_r   <= rem_s;
            quo_r   <= quo_s;
            dvs_r   <= dvs_s;
            cnt_r   <= cnt_s;
            q_neg_r <= q_neg_s;
            r_neg_r <= r_neg_s;
        end
    end

    assign bus.stall_o    = stall_s;
    assign bus.valid_o    = valid_s;
    assign bus.hi_div_out = valid_s ? rem_fix_s : {DATA_W{1'b0}};
    assign bus.lo_div_out = valid_s ? quo_fix_s : {DATA_W{1'b0}};

endmodule
